serial_add_seq: RTL and testbench
=================================

// Module: serial_add_seq
// PURPOSE
//   Bit-serial add sequencer. Accepts one WIDTH-bit operand pair plus carry-in
//   over a valid/ready handshake and drives a single 1-bit full-adder cell
//   (built from two half adders) LSB-first, one bit per clock.
//   Returns the WIDTH-bit sum and the carry-out over a second valid/ready handshake.
//   Trades latency for area; sits between an operand source and a result consumer.
// PARAMETERS
//   WIDTH   4   operand/sum width in bits; legal range WIDTH >= 1
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand pair presented
//   in_ready   out  1      sequencer can accept operands (IDLE only)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in
//   out_valid  out  1      sum/cout valid (DONE only)
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  sum bits
//   cout       out  1      final carry-out
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; sum=0, cout=0, out_valid=0, busy=0,
//     in_ready=1; internal shift registers, carry reg and bit counter = 0.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On edge with in_valid&in_ready: latch a,b into shift
//     regs, carry reg=cin, bitcnt=0 -> RUN. No handshake: stay IDLE.
//   RUN: in_ready=0. Each edge: FA cell computes {c,s}=a_sh[0]+b_sh[0]+carry;
//     s shifted into sum reg from MSB side (after WIDTH shifts bit0 sits at LSB);
//     a_sh,b_sh shift right; carry<=c; bitcnt++. On the edge where bitcnt==WIDTH-1
//     -> DONE (exactly WIDTH RUN cycles; WIDTH=1 gives one RUN cycle).
//   DONE: out_valid=1; sum,cout=carry reg held stable until out_ready. On edge
//     with out_ready -> IDLE, out_valid=0 next cycle. No IDLE bypass: a new
//     operand is accepted no earlier than the cycle after the result is taken.
//   Latency: accept at edge 0 -> out_valid high after edge WIDTH.
//     Throughput: one add per WIDTH+2 cycles with out_ready held high.
//   in_valid during RUN/DONE is ignored (in_ready=0); source must hold.
//   Arithmetic: {cout,sum} == a + b + cin, mod 2^(WIDTH+1); no overflow flag.
//   sum output updates only while in RUN; value is stable in DONE and IDLE
//     (retains last result until next RUN).
//   bitcnt width = $clog2(WIDTH) min 1; never wraps (exits RUN at WIDTH-1).
//   Reset mid-RUN/DONE: operation discarded, no out_valid pulse afterwards.
// STRUCTURE
//   Package serial_add_pkg: typedef enum logic [1:0] {S_IDLE,S_RUN,S_DONE}
//     sa_state_t; localparam default width.
//   Sub-module: fa_cell (combinational 1-bit full adder from two half adders
//     + OR); instantiated once. All state lives in serial_add_seq.
// TESTING (WIDTH=4)
//   5+3,cin=0, out_ready=1 -> out_valid 4 cycles after accept; sum=8, cout=0.
//   15+1,cin=0 -> sum=0, cout=1 (carry ripple through all bits).
//   15+15,cin=1 -> sum=15, cout=1 (max value 31).
//   Hold out_ready=0 for 10 cycles in DONE -> sum/cout/out_valid stable;
//     in_valid pulses with new operands ignored; in_ready=0 throughout.
//   Assert rst after 2nd RUN cycle -> immediately IDLE, sum=0, out_valid=0,
//     in_ready=1; then 7+9,cin=0 completes with sum=0, cout=1.
//   Back-to-back: in_valid held high, out_ready=1, 3 random pairs -> one result
//     per 6 cycles, each {cout,sum} matches a+b+cin reference model.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sa_state_t;

    localparam int unsigned SA_DEFAULT_WIDTH = 4;

    // Bit-counter width: enough to hold WIDTH-1, never narrower than one bit.
    function automatic int unsigned sa_cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder built from two half adders and an OR.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum_c,
    output logic carry_c
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    always_comb begin
        ha0_s   = a ^ b;
        ha0_c   = a & b;
        sum_c   = ha0_s ^ cin;
        ha1_c   = ha0_s & cin;
        carry_c = ha0_c | ha1_c;
    end

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer: accepts an operand pair, adds LSB-first through
// one full-adder cell, and returns {cout,sum} over a valid/ready handshake.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned            CNT_W    = sa_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]       LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_t        state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] bitcnt;

    logic             fa_sum_c;
    logic             fa_carry_c;
    logic [WIDTH-1:0] sum_shift_c;
    logic [WIDTH-1:0] a_shift_c;
    logic [WIDTH-1:0] b_shift_c;

    fa_cell u_fa (
        .a       (a_sh[0]),
        .b       (b_sh[0]),
        .cin     (carry),
        .sum_c   (fa_sum_c),
        .carry_c (fa_carry_c)
    );

    // New sum bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
    always_comb begin
        sum_shift_c = (sum >> 1) | (WIDTH'(fa_sum_c) << (WIDTH - 1));
        a_shift_c   = a_sh >> 1;
        b_shift_c   = b_sh >> 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            bitcnt    <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        bitcnt   <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum   <= sum_shift_c;
                    a_sh  <= a_shift_c;
                    b_sh  <= b_shift_c;
                    carry <= fa_carry_c;
                    if (bitcnt == LAST_BIT) begin
                        cout      <= fa_carry_c;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        bitcnt <= bitcnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // Result held until taken; IDLE is entered before any new accept.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq (WIDTH=4): vector table, corner
// sequences, and randomized operations against an arithmetic reference.
module tb_serial_add_seq;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for out_valid", name);
    endtask

    // Reference: plain (W+1)-bit addition.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int budget, output int n);
        n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        if (!out_valid) timeout_fail(name);
    endtask

    // One full transaction with latency and handshake checks; out_ready held high.
    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic [W:0] exp);
        int n;
        out_ready = 1'b1;
        check({name, "_ready_idle"}, 32'(in_ready), 32'd1);
        a = x; b = y; cin = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({name, "_busy_run"}, 32'(busy), 32'd1);
        check({name, "_ready_run"}, 32'(in_ready), 32'd0);
        wait_valid(name, 20, n);
        check({name, "_latency"}, 32'(n), 32'(W));
        check({name, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
        check({name, "_cout"}, 32'(cout), 32'(exp[W]));
        tick();
        check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({name, "_ready_back"}, 32'(in_ready), 32'd1);
        check({name, "_sum_kept"}, 32'(sum), 32'(exp[W-1:0]));
    endtask

    vec_t tab[6];

    initial begin
        int           n;
        logic [W:0]   exp_q[$];
        logic [W:0]   e;
        int           got;
        int           last_cyc;
        int           pushed;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic         rc;

        tab[0] = '{"add5_3",    4'd5,  4'd3,  1'b0, 4'd8,  1'b0};
        tab[1] = '{"add15_1",   4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
        tab[2] = '{"add15_15c", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        tab[3] = '{"add0_0",    4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
        tab[4] = '{"add9_6c",   4'd9,  4'd6,  1'b1, 4'd0,  1'b1};
        tab[5] = '{"add10_5",   4'd10, 4'd5,  1'b0, 4'd15, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            run_op(tab[i].name, tab[i].a, tab[i].b, tab[i].cin, {tab[i].exp_cout, tab[i].exp_sum});

        // Result held with out_ready low; new operands ignored.
        out_ready = 1'b0;
        a = 4'd12; b = 4'd7; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid("hold", 20, n);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            tick();
            check("hold_sum", 32'(sum), 32'd4);
            check("hold_cout", 32'(cout), 32'd1);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("hold_release_valid", 32'(out_valid), 32'd0);
        check("hold_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("hold_no_accept", 32'(busy), 32'd0);

        // Reset after the second RUN cycle.
        a = 4'd3; b = 4'd4; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_pulse", 32'(out_valid), 32'd0);
        end
        run_op("after_rst", 4'd7, 4'd9, 1'b0, 5'h10);

        // Back-to-back with in_valid held high: one result every W+2 cycles.
        pushed = 0; got = 0; last_cyc = -1;
        for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                check("b2b_sum", 32'(sum), 32'(e[W-1:0]));
                check("b2b_cout", 32'(cout), 32'(e[W]));
                if (last_cyc >= 0) check("b2b_interval", 32'(cyc - last_cyc), 32'(W + 2));
                last_cyc = cyc;
                got++;
            end
            if (in_ready) begin
                if (pushed < 3) begin
                    rx = W'($urandom); ry = W'($urandom); rc = 1'($urandom);
                    a = rx; b = ry; cin = rc; in_valid = 1'b1;
                    exp_q.push_back(ref_add(rx, ry, rc));
                    pushed++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        if (got < 3) timeout_fail("b2b");

        // Random operations with random consumer stalls.
        for (int k = 0; k < 20; k++) begin
            int stall;
            rx = W'($urandom); ry = W'($urandom); rc = 1'($urandom);
            e = ref_add(rx, ry, rc);
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
            a = rx; b = ry; cin = rc; in_valid = 1'b1; out_ready = 1'b0;
            tick();
            in_valid = 1'b0;
            wait_valid("rand", 20, n);
            stall = int'($urandom_range(0, 4));
            for (int s = 0; s < stall; s++) tick();
            check("rand_sum", 32'(sum), 32'(e[W-1:0]));
            check("rand_cout", 32'(cout), 32'(e[W]));
            out_ready = 1'b1;
            tick();
            check("rand_done", 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
